// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: widths, op codes, FSM states.
// The optional single-cycle multiplier is selected by MDU_FAST_MUL_EN.
package mdu_pkg;

    localparam int unsigned DW    = 32;
    localparam int unsigned CNT_W = 5;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
    localparam logic [2:0] OP_RSVD  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_e;

    // Sign/mode flags captured when an operation is accepted
    typedef struct packed {
        logic is_mul;
        logic neg_prod;
        logic neg_q;
        logic neg_r;
    } mdu_flags_t;

    function automatic logic [DW-1:0] mag(input logic [DW-1:0] v, input logic signed_op);
        return (signed_op && v[DW-1]) ? DW'(-v) : v;
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface md_unit_if;
    import mdu_pkg::*;

    logic          start;
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          flush;
    logic          busy;
    logic          done;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;

    modport master (output start, op, a, b, flush, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_iter_core.sv
// 2*DW accumulator datapath: shift-add multiply or restoring divide, one bit per step.
module mdu_iter_core
    import mdu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic            mode_div,
    input  logic [DW-1:0]   op_a,
    input  logic [DW-1:0]   op_b,
    output logic [2*DW-1:0] acc
);

    logic [DW-1:0]   opnd;
    logic            mode_q;
    logic [DW:0]     mul_sum;
    logic [DW:0]     trial;
    logic [2*DW-1:0] acc_next;

    // Multiply: add multiplicand to upper half when LSB set, then shift right with carry.
    // Divide: shift partial remainder left, keep the trial subtraction if it did not borrow.
    always_comb begin
        mul_sum  = {1'b0, acc[2*DW-1:DW]} + (acc[0] ? {1'b0, opnd} : {(DW+1){1'b0}});
        trial    = acc[2*DW-1:DW-1] - {1'b0, opnd};
        acc_next = acc;
        if (mode_q) begin
            if (trial[DW]) acc_next = {acc[2*DW-2:0], 1'b0};
            else           acc_next = {trial[DW-1:0], acc[DW-2:0], 1'b1};
        end else begin
            acc_next = {mul_sum, acc[DW-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            opnd   <= '0;
            mode_q <= 1'b0;
        end else if (load) begin
            mode_q <= mode_div;
            opnd   <= mode_div ? op_b : op_a;
            acc    <= {{DW{1'b0}}, (mode_div ? op_a : op_b)};
        end else if (step) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit with architectural HI/LO and busy/done handshake.
// Define MDU_FAST_MUL_EN for a single-cycle multiply path (IDLE -> FIX).
module md_unit
    import mdu_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    md_unit_if.slave  bus
);

    mdu_state_e      state, next_state;
    logic [CNT_W-1:0] cnt;
    mdu_flags_t      flags;
    logic            core_load, core_step, wr_res, wr_hi, wr_lo;
    logic            is_mul_op, is_div_op, signed_op;
    logic [DW-1:0]   a_mag, b_mag;
    logic [2*DW-1:0] acc, raw, prod;
    logic [DW-1:0]   q, r, res_hi, res_lo;

    // Operand decode and magnitude conversion
    always_comb begin
        is_mul_op = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
        is_div_op = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
        signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        a_mag     = mag(bus.a, signed_op);
        b_mag     = mag(bus.b, signed_op);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Next state and datapath controls; flush always wins over start
    always_comb begin
        next_state = state;
        core_load  = 1'b0;
        core_step  = 1'b0;
        wr_res     = 1'b0;
        wr_hi      = 1'b0;
        wr_lo      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.start && !bus.flush) begin
                    if (is_mul_op || is_div_op) begin
                        core_load  = 1'b1;
`ifdef MDU_FAST_MUL_EN
                        next_state = is_mul_op ? ST_FIX : ST_CALC;
`else
                        next_state = ST_CALC;
`endif
                    end
                    wr_hi = (bus.op == OP_MTHI);
                    wr_lo = (bus.op == OP_MTLO);
                end
            end
            ST_CALC: begin
                if (bus.flush) begin
                    next_state = ST_IDLE;
                end else begin
                    core_step = 1'b1;
                    if (cnt == CNT_W'(DW - 1)) next_state = ST_FIX;
                end
            end
            ST_FIX: begin
                next_state = ST_IDLE;
                wr_res     = !bus.flush;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            cnt <= '0;
        else if (core_load) cnt <= '0;
        else if (core_step) cnt <= cnt + CNT_W'(1);
    end

    // Divide by zero keeps the all-ones quotient regardless of operand signs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags <= '0;
        end else if (core_load) begin
            flags.is_mul   <= is_mul_op;
            flags.neg_prod <= signed_op && (bus.a[DW-1] ^ bus.b[DW-1]);
            flags.neg_q    <= signed_op && (bus.a[DW-1] ^ bus.b[DW-1]) && (bus.b != '0);
            flags.neg_r    <= signed_op && bus.a[DW-1];
        end
    end

    mdu_iter_core u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (core_load),
        .step     (core_step),
        .mode_div (is_div_op),
        .op_a     (a_mag),
        .op_b     (b_mag),
        .acc      (acc)
    );

`ifdef MDU_FAST_MUL_EN
    logic [2*DW-1:0] fast_prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         fast_prod <= '0;
        else if (core_load && is_mul_op) fast_prod <= (2*DW)'(a_mag) * (2*DW)'(b_mag);
    end

    assign raw = flags.is_mul ? fast_prod : acc;
`else
    assign raw = acc;
`endif

    // Sign fix-up and HI/LO mapping
    always_comb begin
        prod   = flags.neg_prod ? (2*DW)'(-raw) : raw;
        q      = raw[DW-1:0];
        r      = raw[2*DW-1:DW];
        res_hi = flags.neg_r ? DW'(-r) : r;
        res_lo = flags.neg_q ? DW'(-q) : q;
        if (flags.is_mul) begin
            res_hi = prod[2*DW-1:DW];
            res_lo = prod[DW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.hi   <= '0;
            bus.lo   <= '0;
        end else begin
            bus.busy <= (next_state != ST_IDLE);
            bus.done <= wr_res;
            if (wr_res) begin
                bus.hi <= res_hi;
                bus.lo <= res_lo;
            end else begin
                if (wr_hi) bus.hi <= bus.a;
                if (wr_lo) bus.lo <= bus.a;
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit with a cycle-level reference model of HI/LO/busy/done.
module tb_md_unit;
    import mdu_pkg::*;

`ifdef MDU_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk;
    logic rst;
    md_unit_if bus();

    md_unit dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of one operation as {hi, lo}
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, sq, sr;
        longint unsigned ux, uy, uq, ur;
        logic [63:0] res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        res = '0;
        case (op)
            OP_MULT:  res = 64'(sx * sy);
            OP_MULTU: res = 64'(ux * uy);
            OP_DIV: begin
                if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
                else begin
                    sq = sx / sy;
                    sr = sx % sy;
                    res = {sr[31:0], sq[31:0]};
                end
            end
            OP_DIVU: begin
                if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
                else begin
                    uq = ux / uy;
                    ur = ux % uy;
                    res = {ur[31:0], uq[31:0]};
                end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    logic [31:0] m_hi, m_lo;
    logic [63:0] m_pend;
    int          m_rem;
    logic        m_done;

    // Reference model: remaining-cycle countdown per accepted request
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hi = '0; m_lo = '0; m_rem = 0; m_done = 1'b0; m_pend = '0;
        end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                if (bus.flush) m_rem = 0;
                else begin
                    m_rem--;
                    if (m_rem == 0) begin
                        {m_hi, m_lo} = m_pend;
                        m_done = 1'b1;
                    end
                end
            end else if (bus.start && !bus.flush) begin
                case (bus.op)
                    OP_MULT, OP_MULTU: begin m_pend = model(bus.op, bus.a, bus.b); m_rem = FAST ? 1 : 33; end
                    OP_DIV, OP_DIVU:   begin m_pend = model(bus.op, bus.a, bus.b); m_rem = 33; end
                    OP_MTHI: m_hi = bus.a;
                    OP_MTLO: m_lo = bus.a;
                    default: ;
                endcase
            end
        end
    end

    // Compare process: every cycle outside reset
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", 64'(bus.busy), 64'(m_rem > 0));
            chk("done", 64'(bus.done), 64'(m_done));
            chk("hi",   64'(bus.hi),   64'(m_hi));
            chk("lo",   64'(bus.lo),   64'(m_lo));
            if (bus.done) done_cnt++;
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = x; bus.b = y;
        @(negedge clk);
        bus.start = 1'b0; bus.op = OP_NOP;
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        bit seen;
        int exp_lat;
        n = 0; seen = 1'b0;
        exp_lat = (FAST && (op == OP_MULT || op == OP_MULTU)) ? 1 : 33;
        issue(op, x, y);
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (bus.done) begin n = i; seen = 1'b1; break; end
        end
        chk({name, "_timeout"}, 64'(seen), 64'd1);
        chk({name, "_lat"}, 64'(n), 64'(exp_lat));
        chk({name, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        chk({name, "_lo"}, 64'(bus.lo), 64'(exp_lo));
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.op = OP_NOP; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_hi",   64'(bus.hi),   64'd0);
        chk("rst_lo",   64'(bus.lo),   64'd0);
        rst = 1'b0;

        run_op("mult_m1x2",   OP_MULT,  32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu_max2",  OP_MULTU, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE);
        run_op("mult_m3x5",   OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("div_m7by2",   OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7bym2",   OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
        run_op("div_minbym1", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
        run_op("divu_7by0",   OP_DIVU,  32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF);
        run_op("divu_100by7", OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14);

        // Flush mid-divide; a start while busy must be ignored
        issue(OP_MTHI, 32'h11, 32'd0);
        issue(OP_MTLO, 32'h22, 32'd0);
        chk("mt_hi", 64'(bus.hi), 64'h11);
        chk("mt_lo", 64'(bus.lo), 64'h22);
        done_cnt = 0;
        issue(OP_DIVU, 32'd100, 32'd7);
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MTHI; bus.a = 32'd5;
        @(negedge clk);
        bus.start = 1'b0; bus.op = OP_NOP;
        repeat (6) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_busy", 64'(bus.busy), 64'd0);
        chk("flush_hi",   64'(bus.hi),   64'h11);
        chk("flush_lo",   64'(bus.lo),   64'h22);
        repeat (40) @(negedge clk);
        chk("flush_no_done", 64'(done_cnt), 64'd0);

        // Asynchronous reset in the middle of an iteration
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", 64'(bus.busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_hi",   64'(bus.hi),   64'd0);
        chk("arst_lo",   64'(bus.lo),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(OP_MTLO, 32'h1234, 32'd0);
        chk("mtlo_lo",   64'(bus.lo),   64'h1234);
        chk("mtlo_busy", 64'(bus.busy), 64'd0);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
